// File: rtl/nt_mon_pkg.sv
// Shared types and default parameters for the Nt-node trigger monitor.
// Imported by the delay line and the monitor top level.
package nt_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } nt_state_e;

  localparam int NT_DEF_WIDTH  = 8;
  localparam int NT_DEF_DEPTH  = 3;
  localparam int NT_DEF_CNT_W  = 8;
  localparam int NT_DEF_THRESH = 4;

endpackage

// File: rtl/nt_node_delay_line.sv
// Enabled WIDTH x DEPTH shift register with synchronous clear.
// The fill counter saturates at DEPTH, so 'filled' means the last stage holds a real sample.
module nt_node_delay_line
  import nt_mon_pkg::*;
#(
  parameter int WIDTH = NT_DEF_WIDTH,
  parameter int DEPTH = NT_DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             filled
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  stage_r [DEPTH];
  logic [FILL_W-1:0] fill_r;

  // Shift stages and count valid beats; clear flushes everything.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_r[k] <= '0;
      end
      fill_r <= '0;
    end else if (en) begin
      stage_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
      if (fill_r != DEPTH_F) begin
        fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign dout   = stage_r[DEPTH-1];
  assign filled = (fill_r == DEPTH_F);

endmodule

// File: rtl/nt_node_trigger_monitor.sv
// Rare-activation monitor: delays tapped node values, matches the oldest stage
// against a masked pattern, counts hits and raises trig at THRESH.
module nt_node_trigger_monitor
  import nt_mon_pkg::*;
#(
  parameter int WIDTH  = NT_DEF_WIDTH,
  parameter int DEPTH  = NT_DEF_DEPTH,
  parameter int CNT_W  = NT_DEF_CNT_W,
  parameter int THRESH = NT_DEF_THRESH
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic [WIDTH-1:0] in_nodes,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_load,
  input  logic             arm,
  input  logic             clear,
  output logic [CNT_W-1:0] hit_count,
  output logic             trig,
  output logic [1:0]       state
);

  localparam logic [CNT_W:0]   THRESH_W = (CNT_W + 1)'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] pattern_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] hit_count_r;
  logic             trig_r;
  nt_state_e        state_r;
  nt_state_e        state_next_s;
  logic [WIDTH-1:0] tail_s;
  logic             filled_s;
  logic             match_s;
  logic             hit_s;
  logic [CNT_W:0]   cnt_inc_s;

  nt_node_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk    (I1470_clk),
    .rst    (I1477_rst),
    .clr    (clear),
    .en     (in_valid),
    .din    (in_nodes),
    .dout   (tail_s),
    .filled (filled_s)
  );

  // An all-zero mask is treated as "no condition" rather than "always match".
  assign match_s   = (mask_r != '0) && (((tail_s ^ pattern_r) & mask_r) == '0);
  assign hit_s     = in_valid && filled_s && match_s &&
                     ((state_r == ST_ARMED) || (state_r == ST_TRIGGERED));
  assign cnt_inc_s = {1'b0, hit_count_r} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_next_s = ST_IDLE;
    if (clear) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm) begin
            state_next_s = ST_ARMED;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (hit_s && (cnt_inc_s >= THRESH_W)) begin
            state_next_s = ST_TRIGGERED;
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_TRIGGERED: state_next_s = ST_TRIGGERED;
        default:      state_next_s = ST_IDLE;
      endcase
    end
  end

  // State, trigger flag and saturating hit counter.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_r     <= ST_IDLE;
      trig_r      <= 1'b0;
      hit_count_r <= '0;
    end else begin
      state_r <= state_next_s;
      trig_r  <= (state_next_s == ST_TRIGGERED);
      if (clear) begin
        hit_count_r <= '0;
      end else if (hit_s && (hit_count_r != CNT_MAX)) begin
        hit_count_r <= cnt_inc_s[CNT_W-1:0];
      end
    end
  end

  // Pattern/mask are only writable while idle and survive clear.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      pattern_r <= '0;
      mask_r    <= '0;
    end else if (!clear && cfg_load && (state_r == ST_IDLE)) begin
      pattern_r <= cfg_pattern;
      mask_r    <= cfg_mask;
    end
  end

  assign hit_count = hit_count_r;
  assign trig      = trig_r;
  assign state     = state_r;

endmodule

// File: tb/tb_nt_node_trigger_monitor.sv
// Directed bench for nt_node_trigger_monitor: default instance plus a
// narrow-counter instance for saturation.
module tb_nt_node_trigger_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_nodes;
  logic       in_valid;
  logic [7:0] cfg_pattern;
  logic [7:0] cfg_mask;
  logic       cfg_load;
  logic       arm;
  logic       clear;
  logic [7:0] hit_count;
  logic       trig;
  logic [1:0] state;

  logic       rst2;
  logic [7:0] in_nodes2;
  logic       in_valid2;
  logic       cfg_load2;
  logic       arm2;
  logic [2:0] hit_count2;
  logic       trig2;
  logic [1:0] state2;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  nt_node_trigger_monitor dut (
    .I1470_clk   (clk),
    .I1477_rst   (rst),
    .in_nodes    (in_nodes),
    .in_valid    (in_valid),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_load    (cfg_load),
    .arm         (arm),
    .clear       (clear),
    .hit_count   (hit_count),
    .trig        (trig),
    .state       (state)
  );

  nt_node_trigger_monitor #(.WIDTH(8), .DEPTH(3), .CNT_W(3), .THRESH(4)) dut_sat (
    .I1470_clk   (clk),
    .I1477_rst   (rst2),
    .in_nodes    (in_nodes2),
    .in_valid    (in_valid2),
    .cfg_pattern (8'hA5),
    .cfg_mask    (8'hFF),
    .cfg_load    (cfg_load2),
    .arm         (arm2),
    .clear       (1'b0),
    .hit_count   (hit_count2),
    .trig        (trig2),
    .state       (state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_nodes = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_nodes = 8'hFF; in_valid = 1'b1;
    cfg_pattern = 8'h00; cfg_mask = 8'h00; cfg_load = 1'b0; arm = 1'b0; clear = 1'b0;
    rst2 = 1'b1; in_nodes2 = 8'h00; in_valid2 = 1'b0; cfg_load2 = 1'b0; arm2 = 1'b0;

    // 1. reset with valid activity
    tick(); tick();
    chk("rst_cnt", 32'(hit_count), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b0; in_valid = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 3; i++) beat(8'h00);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_state", 32'(state), 32'd1);
    beat(8'h00);
    chk("mask0_nohit", 32'(hit_count), 32'd0);

    // 2. trigger: load + arm together after flush
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    cfg_pattern = 8'hA5; cfg_mask = 8'hFF; cfg_load = 1'b1; arm = 1'b1;
    tick();
    cfg_load = 1'b0; arm = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      beat(8'hA5);
      chk($sformatf("trg_cnt%0d", i), 32'(hit_count), (i < 4) ? 32'd0 : 32'(i - 3));
      if (i == 6) chk("trg_pre_state", 32'(state), 32'd1);
      if (i == 6) chk("trg_pre_trig", 32'(trig), 32'd0);
    end
    chk("trg_trig", 32'(trig), 32'd1);
    chk("trg_state", 32'(state), 32'd2);

    // 3. masking and gaps
    clear = 1'b1; tick(); clear = 1'b0;
    cfg_pattern = 8'h05; cfg_mask = 8'h0F; cfg_load = 1'b1; arm = 1'b1;
    tick();
    cfg_load = 1'b0; arm = 1'b0;
    beat(8'hF5); tick(); tick();
    beat(8'h35); tick(); tick();
    beat(8'h14); tick(); tick();
    chk("gap_cnt0", 32'(hit_count), 32'd0);
    beat(8'hA5);
    chk("msk_b4", 32'(hit_count), 32'd1);
    tick(); tick();
    chk("msk_gap_hold", 32'(hit_count), 32'd1);
    beat(8'h00);
    chk("msk_b5", 32'(hit_count), 32'd2);
    beat(8'h00);
    chk("msk_b6_miss", 32'(hit_count), 32'd2);
    beat(8'h00);
    chk("msk_b7", 32'(hit_count), 32'd3);
    chk("msk_state", 32'(state), 32'd1);

    // 5. config lock while armed
    cfg_pattern = 8'h00; cfg_mask = 8'hFF; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    beat(8'hA5);
    chk("lock_b8", 32'(hit_count), 32'd3);
    chk("lock_state8", 32'(state), 32'd1);
    beat(8'hA5); beat(8'hA5); beat(8'hA5);
    chk("lock_b11", 32'(hit_count), 32'd4);
    chk("lock_trig", 32'(trig), 32'd1);

    // 4. clear beats arm
    clear = 1'b1; arm = 1'b1; tick(); clear = 1'b0; arm = 1'b0;
    chk("cp_state", 32'(state), 32'd0);
    chk("cp_cnt", 32'(hit_count), 32'd0);
    chk("cp_trig", 32'(trig), 32'd0);
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 3; i++) beat(8'hA5);
    chk("cp_refill", 32'(hit_count), 32'd0);
    beat(8'hA5);
    chk("cp_first_hit", 32'(hit_count), 32'd1);

    // 6. saturation on narrow counter
    cfg_load2 = 1'b1; arm2 = 1'b1; tick(); cfg_load2 = 1'b0; arm2 = 1'b0;
    in_nodes2 = 8'hA5;
    for (int i = 1; i <= 20; i++) begin
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      if (i == 7)  chk("sat_cnt7", 32'(hit_count2), 32'd4);
      if (i == 7)  chk("sat_trig7", 32'(trig2), 32'd1);
      if (i == 10) chk("sat_cnt10", 32'(hit_count2), 32'd7);
    end
    chk("sat_cnt20", 32'(hit_count2), 32'd7);
    chk("sat_trig20", 32'(trig2), 32'd1);
    chk("sat_state20", 32'(state2), 32'd2);

    // mid-run reset
    rst = 1'b1; in_valid = 1'b1; in_nodes = 8'hA5; tick(); rst = 1'b0; in_valid = 1'b0;
    chk("mrst_cnt", 32'(hit_count), 32'd0);
    chk("mrst_state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/nt_node_trigger_monitor.md
# nt_node_trigger_monitor

Parametrised successor to the fixed Nt-node subcircuits in the trojan-detection benchmark set. It delays a WIDTH-bit vector of internal node values through a DEPTH-stage enabled register pipeline and compares the oldest stage against a programmable masked pattern. Qualifying matches are counted, and `trig` is raised once the count reaches THRESH. It sits beside a benchmark netlist and taps the netlist's node wires, giving rare-activation monitoring with runtime-selectable condition, depth and threshold.

## Interface
- WIDTH, 8, number of monitored node bits (≥1)
- DEPTH, 3, pipeline stages (≥2)
- CNT_W, 8, hit counter width (≥2)
- THRESH, 4, hits required to trigger (1 ≤ THRESH ≤ 2^CNT_W−1)
- I1470_clk  in  1  sole clock, rising edge
- I1477_rst  in  1  reset: one clock; reset is synchronous and active-high
- in_nodes  in  WIDTH  sampled node values
- in_valid  in  1  sample enable; pipeline shifts only when high
- cfg_pattern  in  WIDTH  match pattern
- cfg_mask  in  WIDTH  bit i compared only if mask[i]=1
- cfg_load  in  1  capture pattern/mask (IDLE only)
- arm  in  1  start monitoring (IDLE only)
- clear  in  1  abort/flush from any state
- hit_count  out  CNT_W  saturating match count
- trig  out  1  high while state is TRIGGERED
- state  out  2  current FSM state

## Operation
- **Reset.** Clears stages, fill counter, pattern_q, mask_q, hit_count and trig to 0, with state = IDLE.
- **Pipeline.**
  - When in_valid=1: stage[0]←in_nodes, stage[k]←stage[k−1].
  - When in_valid=0: all stages hold.
- **Fill counter.** Counts valid beats and saturates at DEPTH. `filled` = (fill == DEPTH).
- **Match.**
  - match = (mask_q ≠ 0) && (((stage[DEPTH−1] ^ pattern_q) & mask_q) == 0).
  - mask_q = 0 never matches.
- **Hit.** hit = in_valid && filled && match && state ∈ {ARMED, TRIGGERED}. This evaluates the sample being shifted out.
- **Counter.** Increments by 1 on hit and saturates at 2^CNT_W−1. No wrap.
- **FSM.**
  - IDLE → ARMED on arm.
  - ARMED → TRIGGERED on the edge where hit && hit_count+1 ≥ THRESH.
  - TRIGGERED holds until clear.
  - Any state → IDLE on clear.
- **clear.** Zeroes the stages, fill counter and hit_count. Keeps pattern_q and mask_q.
- **cfg_load.** Accepted in IDLE only and ignored in other states. A cfg_load and arm in the same IDLE cycle both take effect; the new pattern is used from the next cycle.
- **Priority.** I1477_rst > clear > arm/cfg_load.
  - clear and arm in the same cycle: result is IDLE.
  - Reset asserted mid-run: full reset on that edge, regardless of in_valid.

## Timing
- Every output is registered; no combinational input→output path.
- The sample taken at valid beat n is evaluated at valid beat n+DEPTH. The first evaluation is at beat DEPTH+1 after reset/clear.
- hit_count updates on the edge of the hit cycle.
- trig and state=TRIGGERED are visible immediately after the edge on which the THRESHth hit is counted.
- in_valid gaps stretch the latency but lose no samples.

## Structure
- **Package nt_mon_pkg.**
  - State enum: IDLE=2'd0, ARMED=2'd1, TRIGGERED=2'd2; 2'd3 is unused and decodes to IDLE on the next edge.
  - Default parameter constants.
- **Sub-module nt_node_delay_line.**
  - WIDTH×DEPTH enabled shift register with synchronous clear.
  - Outputs the last stage and the fill flag.
- **Top level.** Holds config registers, match logic, counter and FSM.

## Test plan
All scenarios use WIDTH=8, DEPTH=3, THRESH=4, CNT_W=8 unless stated.

1. **Reset.** I1477_rst=1 for 2 cycles with in_valid=1 and in_nodes=0xFF → hit_count=0, trig=0, state=0. Afterwards, 3 beats of 0x00 then arm produce no hit with mask 0.
2. **Trigger.**
   - Stimulus: cfg_load pattern=0xA5, mask=0xFF; arm; 7 valid beats of 0xA5.
   - Response: hit_count 0,0,0,1,2,3,4 after beats 1..7. trig=1 and state=2 after beat 7.
3. **Masking and gaps.**
   - Stimulus: pattern=0x05, mask=0x0F; stream 0xF5,0x35,0x14,0xA5 with in_valid low for 2 cycles between each beat, then 3 beats of 0x00.
   - Response: 3 hits, from 0xF5, 0x35 and 0xA5 (0x14 misses). Counts do not change during gaps.
4. **Clear priority.** In TRIGGERED, assert clear and arm together → state=IDLE, hit_count=0, trig=0. A following arm plus 3 valid beats gives no hit (pipeline refilling).
5. **Config lock.** While ARMED, cfg_load pattern=0x00 → ignored. Matching on 0xA5 continues.
6. **Saturation.** CNT_W=3, THRESH=4, 20 matching beats → hit_count stops at 7 and trig stays 1.
